// File: rtl/elastic_latch.sv
// Handshaked first-word-fall-through pipeline latch carrying an opaque payload.
// It holds DEPTH entries, supports a global stall (en) and a synchronous flush, and tracks peak occupancy.
module elastic_latch #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  count,
    output logic [CNTW-1:0]  max_count
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt, max_cnt;
    logic             push, pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // in_ready deliberately ignores out_ready: a full buffer never accepts in its draining cycle.
    assign in_ready  = en & ~flush & ~RST & (cnt < DEPTH_C);
    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & en & ~flush;
    assign count     = cnt;
    assign max_count = max_cnt;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = cnt;
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else begin
            if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
            if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt_nxt = cnt + CNTW'(1);
                2'b01:   cnt_nxt = cnt - CNTW'(1);
                default: cnt_nxt = cnt;
            endcase
        end
    end

    // Control state: pointers, occupancy, sticky high-water mark.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            max_cnt <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            cnt    <= cnt_nxt;
            if (cnt_nxt > max_cnt) max_cnt <= cnt_nxt;
        end
    end

    // Payload storage is never reset; the out_data mux hides stale entries.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_elastic_latch.sv
// Directed bench for elastic_latch: three instances (DEPTH=2, 3, 1) with hand-computed expectations.
module tb_elastic_latch;

    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // DEPTH=2 instance
    logic         a_en, a_flush, a_iv, a_ir, a_ov, a_or;
    logic [W-1:0] a_id, a_od;
    logic [1:0]   a_cnt, a_max;
    // DEPTH=3 instance
    logic         b_en, b_flush, b_iv, b_ir, b_ov, b_or;
    logic [W-1:0] b_id, b_od;
    logic [1:0]   b_cnt, b_max;
    // DEPTH=1 instance
    logic         c_en, c_flush, c_iv, c_ir, c_ov, c_or;
    logic [W-1:0] c_id, c_od;
    logic [0:0]   c_cnt, c_max;

    elastic_latch #(.WIDTH(W), .DEPTH(2)) u_a (
        .CLK(CLK), .RST(RST), .en(a_en), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .count(a_cnt), .max_count(a_max));

    elastic_latch #(.WIDTH(W), .DEPTH(3)) u_b (
        .CLK(CLK), .RST(RST), .en(b_en), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .count(b_cnt), .max_count(b_max));

    elastic_latch #(.WIDTH(W), .DEPTH(1)) u_c (
        .CLK(CLK), .RST(RST), .en(c_en), .flush(c_flush),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .count(c_cnt), .max_count(c_max));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // DEPTH=3 backpressure table: inputs then expected ir/ov/od/cnt per cycle
    logic       w_iv  [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [7:0] w_id  [11] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 0, 0, 0, 0, 0, 0};
    logic       w_or  [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic       w_ir  [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic       w_ov  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] w_od  [11] = '{8'h00, 8'h11, 8'h12, 8'h12, 8'h13, 8'h13, 8'h14, 8'h14, 8'h15, 8'h15, 8'h00};
    logic [1:0] w_cnt [11] = '{0, 1, 1, 2, 2, 3, 2, 2, 1, 1, 0};

    initial begin
        RST = 1'b1;
        a_en = 1; a_flush = 0; a_iv = 0; a_id = '0; a_or = 0;
        b_en = 1; b_flush = 0; b_iv = 0; b_id = '0; b_or = 0;
        c_en = 1; c_flush = 0; c_iv = 0; c_id = '0; c_or = 0;

        // Reset for two cycles
        step();
        chk("rst_a_ir",  a_ir,  0);
        chk("rst_a_ov",  a_ov,  0);
        chk("rst_a_od",  a_od,  0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_max", a_max, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_c_ov",  c_ov,  0);
        step();
        RST = 1'b0;
        #1;
        chk("post_rst_a_ir", a_ir, 1);

        // Fill DEPTH=2 with out_ready low
        a_iv = 1; a_id = 16'hA;
        #1; chk("fill_ir0", a_ir, 1); chk("fill_ov0", a_ov, 0);
        step();
        a_id = 16'hB;
        #1; chk("fill_ov1", a_ov, 1); chk("fill_od1", a_od, 16'hA); chk("fill_ir1", a_ir, 1);
        step();
        a_iv = 0;
        #1;
        chk("fill_cnt", a_cnt, 2);
        chk("fill_ir",  a_ir,  0);
        chk("fill_od",  a_od,  16'hA);
        chk("fill_max", a_max, 2);

        // Flush with a competing push of 0xF
        a_flush = 1; a_iv = 1; a_id = 16'hF;
        #1; chk("flush_ir", a_ir, 0);
        step();
        a_flush = 0; a_iv = 0;
        #1;
        chk("flush_cnt", a_cnt, 0);
        chk("flush_ov",  a_ov,  0);
        chk("flush_od",  a_od,  0);
        chk("flush_max", a_max, 2);
        step();
        chk("flush_ov_late", a_ov, 0);

        // Streaming 0x1..0x8 with out_ready high
        a_or = 1;
        for (int k = 0; k < 10; k++) begin
            a_iv = (k < 8);
            a_id = W'(k + 1);
            #1;
            if (k < 8) chk($sformatf("strm_ir%0d", k), a_ir, 1);
            if (k >= 1 && k <= 8) begin
                chk($sformatf("strm_ov%0d", k), a_ov, 1);
                chk($sformatf("strm_od%0d", k), a_od, k);
            end
            if (k == 9) chk("strm_empty", a_ov, 0);
            step();
        end

        // Stall: head 0x5, en low for three cycles
        a_iv = 1; a_id = 16'h5; a_or = 0;
        step();
        a_en = 0; a_or = 1; a_id = 16'h6;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_cnt%0d", k), a_cnt, 1);
            chk($sformatf("stall_od%0d", k),  a_od,  16'h5);
            chk($sformatf("stall_ir%0d", k),  a_ir,  0);
            step();
        end
        a_en = 1;
        #1; chk("unstall_ir", a_ir, 1); chk("unstall_od", a_od, 16'h5);
        step();
        a_iv = 0;
        #1; chk("unstall_od6", a_od, 16'h6); chk("unstall_cnt", a_cnt, 1);
        step();
        chk("unstall_drain", a_cnt, 0);
        chk("a_max_final",   a_max, 2);

        // DEPTH=3 backpressure across pointer wrap
        for (int k = 0; k < 11; k++) begin
            b_iv = w_iv[k];
            b_id = W'(w_id[k]);
            b_or = w_or[k];
            #1;
            chk($sformatf("wrap_ir%0d", k),  b_ir,  w_ir[k]);
            chk($sformatf("wrap_ov%0d", k),  b_ov,  w_ov[k]);
            chk($sformatf("wrap_od%0d", k),  b_od,  w_od[k]);
            chk($sformatf("wrap_cnt%0d", k), b_cnt, w_cnt[k]);
            step();
        end
        chk("wrap_max", b_max, 3);

        // DEPTH=1: accepts every second cycle
        c_or = 1; c_iv = 1;
        for (int k = 0; k < 6; k++) begin
            c_id = W'(16'h21 + k / 2);
            #1;
            chk($sformatf("d1_ir%0d", k), c_ir, (k % 2 == 0));
            chk($sformatf("d1_ov%0d", k), c_ov, (k % 2));
            chk($sformatf("d1_od%0d", k), c_od, (k % 2) ? 16'h21 + k / 2 : 0);
            step();
        end
        c_iv = 0;
        chk("d1_max", c_max, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
